// File: rtl/pin_grid_pkg.sv
// rtl/pin_grid_pkg.sv - shared types and geometry helpers for the pin grid sequencer
package pin_grid_pkg;

    localparam int DEF_ROWS    = 4;
    localparam int DEF_COLS    = 8;
    localparam int DEF_STEPS   = 16;
    localparam int DEF_DWELL_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

    function automatic int calc_npins(input int rows, input int cols);
        return rows * cols;
    endfunction

    function automatic int calc_aw(input int steps);
        return (steps <= 2) ? 1 : $clog2(steps);
    endfunction

    // Step record at the default grid geometry.
    typedef struct packed {
        logic [DEF_ROWS*DEF_COLS-1:0] mask;
        logic [DEF_DWELL_W-1:0]       dwell;
    } step_t;

endpackage

// File: rtl/pin_step_mem.sv
// rtl/pin_step_mem.sv - step table register file, one write port, one async read port
module pin_step_mem
    import pin_grid_pkg::*;
#(
    parameter int STEPS   = DEF_STEPS,
    parameter int MASK_W  = DEF_ROWS * DEF_COLS,
    parameter int DWELL_W = DEF_DWELL_W,
    parameter int AW      = calc_aw(DEF_STEPS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [MASK_W-1:0]  wr_mask,
    input  logic [DWELL_W-1:0] wr_dwell,
    input  logic [AW-1:0]      rd_addr,
    output logic [MASK_W-1:0]  rd_mask,
    output logic [DWELL_W-1:0] rd_dwell
);

    logic [MASK_W-1:0]  mask_q  [STEPS];
    logic [MASK_W-1:0]  mask_d  [STEPS];
    logic [DWELL_W-1:0] dwell_q [STEPS];
    logic [DWELL_W-1:0] dwell_d [STEPS];
    logic               in_range;

    // Out-of-range addresses are accepted upstream but land nowhere.
    assign in_range = ({1'b0, wr_addr} < (AW+1)'(STEPS));

    always_comb begin
        mask_d  = mask_q;
        dwell_d = dwell_q;
        if (wr_en && in_range) begin
            mask_d[wr_addr]  = wr_mask;
            dwell_d[wr_addr] = wr_dwell;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STEPS; i++) begin
                mask_q[i]  <= '0;
                dwell_q[i] <= '0;
            end
        end else begin
            mask_q  <= mask_d;
            dwell_q <= dwell_d;
        end
    end

    assign rd_mask  = mask_q[rd_addr];
    assign rd_dwell = dwell_q[rd_addr];

endmodule

// File: rtl/pin_grid_sequencer.sv
// rtl/pin_grid_sequencer.sv - plays a table of pin-grid masks with per-step dwell
// Optional feature macro: PIN_LOCK_EN (per-pin lock register masking pin_drive).
module pin_grid_sequencer
    import pin_grid_pkg::*;
#(
    parameter int ROWS    = DEF_ROWS,
    parameter int COLS    = DEF_COLS,
    parameter int STEPS   = DEF_STEPS,
    parameter int DWELL_W = DEF_DWELL_W,
    localparam int NPINS  = calc_npins(ROWS, COLS),
    localparam int AW     = calc_aw(STEPS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [AW-1:0]      wr_addr,
    input  logic [NPINS-1:0]   wr_mask,
    input  logic [DWELL_W-1:0] wr_dwell,
    input  logic               start,
    input  logic [AW:0]        num_steps,
    input  logic               loop_en,
    input  logic               abort,
`ifdef PIN_LOCK_EN
    input  logic               lock_wr,
    input  logic [NPINS-1:0]   lock_mask,
`endif
    output logic [NPINS-1:0]   pin_drive,
    output logic [AW-1:0]      step_idx,
    output logic               busy,
    output logic               done
);

    seq_state_t         state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic [AW-1:0]      last_q, last_d;
    logic               loop_q, loop_d;
    logic [NPINS-1:0]   drive_q, drive_d;
    logic [AW-1:0]      rd_addr;
    logic [NPINS-1:0]   rd_mask;
    logic [DWELL_W-1:0] rd_dwell;
    logic [AW:0]        n_clamped;
    logic               go;
    logic               at_last;

    assign n_clamped = (num_steps > (AW+1)'(STEPS)) ? (AW+1)'(STEPS) : num_steps;
    assign go        = start && (num_steps != '0);
    assign at_last   = (idx_q == last_q);

    // Single read port: next step while advancing, otherwise step 0 (start or wrap).
    assign rd_addr = (state_q == DWELL && !at_last) ? idx_q + AW'(1) : '0;

    pin_step_mem #(
        .STEPS   (STEPS),
        .MASK_W  (NPINS),
        .DWELL_W (DWELL_W),
        .AW      (AW)
    ) u_mem (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_valid && wr_ready),
        .wr_addr  (wr_addr),
        .wr_mask  (wr_mask),
        .wr_dwell (wr_dwell),
        .rd_addr  (rd_addr),
        .rd_mask  (rd_mask),
        .rd_dwell (rd_dwell)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            loop_q  <= 1'b0;
            drive_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            loop_q  <= loop_d;
            drive_q <= drive_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: if (go) state_d = DWELL;
                DWELL:      if (cnt_q == '0 && at_last && !loop_q) state_d = DONE;
                default:    state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        last_d  = last_q;
        loop_d  = loop_q;
        drive_d = drive_q;
        if (abort) begin
            drive_d = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (go) begin
                        drive_d = rd_mask;
                        cnt_d   = rd_dwell;
                        idx_d   = '0;
                        last_d  = AW'(n_clamped - (AW+1)'(1));
                        loop_d  = loop_en;
                    end
                end
                DWELL: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end else if (!at_last) begin
                        idx_d   = idx_q + AW'(1);
                        drive_d = rd_mask;
                        cnt_d   = rd_dwell;
                    end else if (loop_q) begin
                        idx_d   = '0;
                        drive_d = rd_mask;
                        cnt_d   = rd_dwell;
                    end else begin
                        drive_d = '0;
                    end
                end
                default: drive_d = '0;
            endcase
        end
    end

    assign busy     = (state_q == DWELL);
    assign done     = (state_q == DONE);
    assign wr_ready = !busy;
    assign step_idx = idx_q;

`ifdef PIN_LOCK_EN
    logic [NPINS-1:0] lock_q, lock_d;

    always_comb begin
        lock_d = lock_q;
        if (lock_wr) lock_d = lock_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lock_q <= '0;
        else        lock_q <= lock_d;
    end

    assign pin_drive = drive_q & ~lock_q;
`else
    assign pin_drive = drive_q;
`endif

endmodule
